// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared types and constants for the serial drive-command receiver
package uart_cmd_pkg;

    localparam int unsigned SYS_CLK_HZ           = 25_000_000;
    localparam int unsigned UART_BAUD            = 9600;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = SYS_CLK_HZ / UART_BAUD;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_CMD_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } rx_state_e;

    localparam logic [7:0] CMD_FWD   = 8'h46;
    localparam logic [7:0] CMD_BACK  = 8'h42;
    localparam logic [7:0] CMD_LEFT  = 8'h4C;
    localparam logic [7:0] CMD_RIGHT = 8'h52;
    localparam logic [7:0] CMD_STOP  = 8'h53;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_FWD   = 4'b0001;
    localparam logic [3:0] DIR_BACK  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam logic [1:0] DRIVE_STOP = 2'd0;
    localparam logic [1:0] DRIVE_GO   = 2'd1;
    localparam logic [1:0] DRIVE_TURN = 2'd2;

    typedef struct packed {
        logic       hit;
        logic [3:0] dir;
        logic [1:0] drive;
    } cmd_dec_t;

    // Uppercase ASCII only; anything else reports hit=0 so the caller holds its outputs.
    function automatic cmd_dec_t decode_cmd(input logic [7:0] b);
        cmd_dec_t d;
        d.hit   = 1'b1;
        d.dir   = DIR_NONE;
        d.drive = DRIVE_STOP;
        case (b)
            CMD_FWD:   begin d.dir = DIR_FWD;   d.drive = DRIVE_GO;   end
            CMD_BACK:  begin d.dir = DIR_BACK;  d.drive = DRIVE_GO;   end
            CMD_LEFT:  begin d.dir = DIR_LEFT;  d.drive = DRIVE_TURN; end
            CMD_RIGHT: begin d.dir = DIR_RIGHT; d.drive = DRIVE_TURN; end
            CMD_STOP:  begin d.dir = DIR_NONE;  d.drive = DRIVE_STOP; end
            default:   d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 receiver (8E1 when UART_CMD_RX_PARITY_EN is defined)
module uart_rx_core
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxData,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       frameErr,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    rx_state_e              state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [2:0]             bit_q;
    logic [7:0]             shift_q;
    logic [7:0]             byte_q;
    logic                   valid_q;
    logic                   ferr_q;
`ifdef UART_CMD_RX_PARITY_EN
    logic                   par_err_q;
`endif
    logic                   rxs;

    assign rxs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '1;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], rxData};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    // A start bit that is already high again at mid-bit was a glitch.
                    if (cnt_q == HALF_CNT) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`ifdef UART_CMD_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q     <= '0;
                        par_err_q <= ^{shift_q, rxs};
                        state_q   <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
`endif
                ST_STOP: begin
                    // Leaving at mid-stop-bit lets a back-to-back start bit be caught at once.
                    if (cnt_q == LAST_CNT) begin
                        cnt_q <= '0;
                        if (!rxs) begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_BREAK;
`ifdef UART_CMD_RX_PARITY_EN
                        end else if (par_err_q) begin
                            ferr_q  <= 1'b1;
                            state_q <= ST_IDLE;
`endif
                        end else begin
                            byte_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (rxs) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rxByte   = byte_q;
    assign rxValid  = valid_q;
    assign frameErr = ferr_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - serial receiver plus registered drive-command decoder (UART_CMD_RX_PARITY_EN selects 8E1)
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxData,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       frameErr,
    output logic       busy,
    output logic [3:0] dirControl,
    output logic [1:0] driveState,
    output logic       cmdValid
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    cmd_dec_t   dec;
    logic [3:0] dir_q;
    logic [1:0] drive_q;
    logic       cmd_valid_q;

    uart_rx_core #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .rxData   (rxData),
        .rxByte   (rx_byte),
        .rxValid  (rx_valid),
        .frameErr (frameErr),
        .busy     (busy)
    );

    always_comb begin
        dec = decode_cmd(rx_byte);
    end

    // Only a good frame carrying a known command moves the motor outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q       <= DIR_NONE;
            drive_q     <= DRIVE_STOP;
            cmd_valid_q <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            if (rx_valid && dec.hit) begin
                dir_q       <= dec.dir;
                drive_q     <= dec.drive;
                cmd_valid_q <= 1'b1;
            end
        end
    end

    assign rxByte     = rx_byte;
    assign rxValid    = rx_valid;
    assign dirControl = dir_q;
    assign driveState = drive_q;
    assign cmdValid   = cmd_valid_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx
module tb_uart_cmd_rx;

    localparam int C    = 16;
    localparam int SYNC = 2;
`ifdef UART_CMD_RX_PARITY_EN
    localparam int LAT = SYNC + 1 + C / 2 + 10 * C;
`else
    localparam int LAT = SYNC + 1 + C / 2 + 9 * C;
`endif

    typedef struct {
        logic [7:0] b;
        bit         is_cmd;
        logic [3:0] dir;
        logic [1:0] st;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxData = 1'b1;
    logic [7:0] rxByte;
    logic       rxValid;
    logic       frameErr;
    logic       busy;
    logic [3:0] dirControl;
    logic [1:0] driveState;
    logic       cmdValid;

    int   checks = 0;
    int   errors = 0;
    int   rx_cnt = 0;
    int   ferr_cnt = 0;
    vec_t exp_q[$];
    vec_t pend;
    bit   pend_valid = 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
    bit   par_flip = 1'b0;
`endif

    uart_cmd_rx #(.CLKS_PER_BIT(C), .SYNC_STAGES(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxData     (rxData),
        .rxByte     (rxByte),
        .rxValid    (rxValid),
        .frameErr   (frameErr),
        .busy       (busy),
        .dirControl (dirControl),
        .driveState (driveState),
        .cmdValid   (cmdValid)
    );

    always #20 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Scoreboard: rxValid pops the next expected byte; the following cycle checks the command outputs.
    always @(negedge clk) begin
        if (rst) begin
            pend_valid = 1'b0;
        end else begin
            if (pend_valid) begin
                check("cmd_valid_follow", cmdValid, pend.is_cmd);
                if (pend.is_cmd) begin
                    check("cmd_dir", dirControl, pend.dir);
                    check("cmd_state", driveState, pend.st);
                end
                pend_valid = 1'b0;
            end else if (cmdValid) begin
                check("cmd_valid_stray", cmdValid, 1'b0);
            end
            if (rxValid) begin
                rx_cnt++;
                if (exp_q.size() == 0) begin
                    check("rx_unexpected", rxByte, 8'h00);
                    check("rx_unexpected_pulse", rxValid, 1'b0);
                end else begin
                    pend = exp_q.pop_front();
                    check("rx_byte", rxByte, pend.b);
                    pend_valid = 1'b1;
                end
            end
            if (frameErr) ferr_cnt++;
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        rxData = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxData = b[i];
            repeat (C) @(negedge clk);
        end
`ifdef UART_CMD_RX_PARITY_EN
        rxData = (^b) ^ par_flip;
        repeat (C) @(negedge clk);
`endif
        rxData = stop_v;
        repeat (C) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b, input bit is_cmd, input logic [3:0] dir, input logic [1:0] st);
        vec_t v;
        v.b = b; v.is_cmd = is_cmd; v.dir = dir; v.st = st;
        exp_q.push_back(v);
        send_frame(b, 1'b1);
    endtask

    vec_t tbl[10];

    initial begin
        int n;
        int rx0;
        int fe0;

        tbl[0] = '{8'h46, 1'b1, 4'b0001, 2'd1};
        tbl[1] = '{8'h41, 1'b0, 4'b0001, 2'd1};
        tbl[2] = '{8'h42, 1'b1, 4'b0010, 2'd1};
        tbl[3] = '{8'h66, 1'b0, 4'b0010, 2'd1};
        tbl[4] = '{8'h4C, 1'b1, 4'b0100, 2'd2};
        tbl[5] = '{8'h00, 1'b0, 4'b0100, 2'd2};
        tbl[6] = '{8'h52, 1'b1, 4'b1000, 2'd2};
        tbl[7] = '{8'hFF, 1'b0, 4'b1000, 2'd2};
        tbl[8] = '{8'h53, 1'b1, 4'b0000, 2'd0};
        tbl[9] = '{8'h73, 1'b0, 4'b0000, 2'd0};

        repeat (4) @(negedge clk);
        check("rst_rxByte", rxByte, 8'h00);
        check("rst_rxValid", rxValid, 1'b0);
        check("rst_frameErr", frameErr, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_dir", dirControl, 4'b0000);
        check("rst_state", driveState, 2'd0);
        check("rst_cmdValid", cmdValid, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // First-frame latency from the pin's falling edge to rxValid.
        n = 0;
        fork
            send_good(8'h46, 1'b1, 4'b0001, 2'd1);
            begin
                while (n < 400 && rxValid !== 1'b1) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        check_range("latency", n, LAT - 1, LAT + 1);
        repeat (C) @(negedge clk);
        check("busy_after_frame", busy, 1'b0);
        check("dir_after_F", dirControl, 4'b0001);

        for (int i = 0; i < 10; i++) begin
            send_good(tbl[i].b, tbl[i].is_cmd, tbl[i].dir, tbl[i].st);
            repeat (C) @(negedge clk);
            check($sformatf("tbl%0d_byte", i), rxByte, tbl[i].b);
            check($sformatf("tbl%0d_dir", i), dirControl, tbl[i].dir);
            check($sformatf("tbl%0d_state", i), driveState, tbl[i].st);
            check($sformatf("tbl%0d_busy", i), busy, 1'b0);
        end

        // Back-to-back R then S with no idle gap.
        fe0 = ferr_cnt;
        rx0 = rx_cnt;
        send_good(8'h52, 1'b1, 4'b1000, 2'd2);
        send_good(8'h53, 1'b1, 4'b0000, 2'd0);
        repeat (3 * C) @(negedge clk);
        check("b2b_rx_count", rx_cnt - rx0, 2);
        check("b2b_no_ferr", ferr_cnt - fe0, 0);
        check("b2b_dir", dirControl, 4'b0000);

        // Bad stop bit followed by a held-low line.
        send_good(8'h46, 1'b1, 4'b0001, 2'd1);
        repeat (C) @(negedge clk);
        fe0 = ferr_cnt;
        rx0 = rx_cnt;
        send_frame(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        check("break_busy_held", busy, 1'b1);
        rxData = 1'b1;
        n = 0;
        while (n < 20 && busy !== 1'b0) begin
            @(negedge clk);
            n++;
        end
        check_range("break_busy_drop", n, 1, 10);
        repeat (C) @(negedge clk);
        check("ferr_count", ferr_cnt - fe0, 1);
        check("ferr_no_rx", rx_cnt - rx0, 0);
        check("ferr_rxByte", rxByte, 8'h46);
        check("ferr_dir", dirControl, 4'b0001);
        check("ferr_state", driveState, 2'd1);

        // Short glitch on an idle line.
        fe0 = ferr_cnt;
        rx0 = rx_cnt;
        rxData = 1'b0;
        repeat (5) @(negedge clk);
        rxData = 1'b1;
        n = 5;
        while (n < 30 && busy !== 1'b0) begin
            @(negedge clk);
            n++;
        end
        check_range("glitch_busy_drop", n, 6, 12);
        repeat (2 * C) @(negedge clk);
        check("glitch_no_rx", rx_cnt - rx0, 0);
        check("glitch_no_ferr", ferr_cnt - fe0, 0);

`ifdef UART_CMD_RX_PARITY_EN
        send_good(8'h53, 1'b1, 4'b0000, 2'd0);
        repeat (C) @(negedge clk);
        check("par_good_dir", dirControl, 4'b0000);
        send_good(8'h46, 1'b1, 4'b0001, 2'd1);
        repeat (C) @(negedge clk);
        fe0 = ferr_cnt;
        rx0 = rx_cnt;
        par_flip = 1'b1;
        send_frame(8'h53, 1'b1);
        par_flip = 1'b0;
        repeat (C) @(negedge clk);
        check("par_bad_ferr", ferr_cnt - fe0, 1);
        check("par_bad_no_rx", rx_cnt - rx0, 0);
        check("par_bad_dir", dirControl, 4'b0001);
`endif

        // Unknown byte after F holds the command, then reset aborts the next frame.
        send_good(8'h46, 1'b1, 4'b0001, 2'd1);
        send_good(8'h41, 1'b0, 4'b0001, 2'd1);
        repeat (C) @(negedge clk);
        check("unknown_rxByte", rxByte, 8'h41);
        check("unknown_dir", dirControl, 4'b0001);
        fe0 = ferr_cnt;
        rx0 = rx_cnt;
        rxData = 1'b0;
        repeat (3 * C) @(negedge clk);
        check("midframe_busy", busy, 1'b1);
        rst = 1'b1;
        rxData = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_rxByte", rxByte, 8'h00);
        check("midrst_busy", busy, 1'b0);
        check("midrst_dir", dirControl, 4'b0000);
        check("midrst_state", driveState, 2'd0);
        check("midrst_cmdValid", cmdValid, 1'b0);
        rst = 1'b0;
        repeat (12 * C) @(negedge clk);
        check("midrst_no_rx", rx_cnt - rx0, 0);
        check("midrst_no_ferr", ferr_cnt - fe0, 0);
        check("midrst_busy_after", busy, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
- UART receiver for the robot's serial link; counterpart to the telemetry UART transmitter.
- Deserialises 8N1 frames arriving on the rxData pin into bytes.
- Decodes single-byte ASCII drive commands into registered dirControl/driveState, which feed the motor/H-bridge control logic.
- Sits beside the existing UART TX on the same 25 MHz system clock.

Parameters:
- CLKS_PER_BIT, 2604, system clocks per bit (25 MHz / 9600 baud); must be ≥ 4; benches use 16.
- SYNC_STAGES, 2, number of input synchroniser flops on rxData (≥ 2).

Ports:
- clk  input  1  system clock, 25 MHz (40 ns period)
- rst  input  1  synchronous, active-high reset
- rxData  input  1  asynchronous serial line; idles high
- rxByte  output  8  last correctly framed byte; holds its value until the next good frame
- rxValid  output  1  one-cycle pulse, rxByte just updated
- frameErr  output  1  one-cycle pulse, stop bit sampled low (or parity bad, see Optional Feature)
- busy  output  1  high from start-bit detection until return to IDLE
- dirControl  output  4  one-hot direction: bit0 fwd, bit1 back, bit2 left, bit3 right; 0 = none
- driveState  output  2  0 stop, 1 drive, 2 turn, 3 unused
- cmdValid  output  1  one-cycle pulse, a recognised command was applied

Behaviour:
- Reset, synchronous and active-high; all outputs and state are 0, except the synchroniser flops, which reset to 1.
- rst asserted mid-frame aborts the frame: no rxValid and no frameErr are emitted.
- The decoder sees only the last synchroniser stage (rxs).
- Receive FSM states: IDLE, START, DATA, [PARITY], STOP, BREAK.
  - IDLE: rxs==0 → START, counter cleared.
  - START: when the counter reaches CLKS_PER_BIT/2 (integer division), sample rxs. If 1 (glitch) → IDLE with no pulses; if 0 → DATA, counter cleared.
  - DATA: sample every CLKS_PER_BIT clocks at mid-bit, LSB first, 8 bits into a shift register. After bit 7 → STOP (or PARITY).
  - STOP: sample at mid-bit.
    - rxs==1: on the next clock rxByte <= shift register, rxValid=1 for one cycle, → IDLE.
    - rxs==0: frameErr=1 for one cycle, rxByte unchanged, → BREAK.
  - BREAK: wait until rxs==1, then → IDLE (handles line break or held-low line).
- Returning to IDLE at mid-stop-bit lets a back-to-back start bit be detected immediately; no inter-frame gap is required.
- busy = (state != IDLE).
- Latency, falling edge on pin → rxValid: SYNC_STAGES + 1 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clocks (±1). The bench checks the window.
- Command decode is registered and triggered by rxValid. The result appears, and cmdValid pulses, exactly 1 clock after rxValid.
  - 0x46 'F' → dirControl=0001, driveState=1
  - 0x42 'B' → 0010, 1
  - 0x4C 'L' → 0100, 2
  - 0x52 'R' → 1000, 2
  - 0x53 'S' → 0000, 0
  - Lowercase equivalents are not accepted.
  - Any other byte: dirControl/driveState hold, no cmdValid; rxValid/rxByte still report the byte.
- A frameErr never changes the command outputs.
- Bit counter is 3 bits and wraps 7→0 on the transition out of DATA. The baud counter width is $clog2(CLKS_PER_BIT).

Optional Feature:
- Macro UART_CMD_RX_PARITY_EN.
- Defined: 8E1 frames. PARITY state samples the 9th bit at mid-bit.
  - Even parity over data+parity mismatch → frameErr pulse after the stop-bit sample, no rxValid, → IDLE (or BREAK if the stop bit is also low).
  - Latency grows by CLKS_PER_BIT.
- Undefined: 8N1 exactly as above; the PARITY state and its logic are absent.

Decomposition:
- Package uart_cmd_pkg:
  - Receive FSM state enum.
  - Command byte constants CMD_FWD/CMD_BACK/CMD_LEFT/CMD_RIGHT/CMD_STOP.
  - DIR_* one-hot constants and DRIVE_STOP/DRIVE_GO/DRIVE_TURN encodings.
- Sub-module uart_rx_core contains the synchroniser, baud counter and FSM, and exports rxByte/rxValid/frameErr/busy.
- uart_cmd_rx instantiates uart_rx_core and adds the registered command decoder. The TX side can reuse the package baud constants.

Test Plan (all with CLKS_PER_BIT=16):
- Send 0x46 as 8N1 → rxValid pulses once with rxByte=0x46; 1 clock later cmdValid=1, dirControl=0001, driveState=1; busy low afterwards.
- Send 'R' then 'S' back-to-back with no idle gap → two rxValid pulses; dirControl goes 1000 then 0000 and driveState goes 2 then 0; no frameErr.
- Send 0x55 with stop bit forced 0, then hold the line low for 40 clocks and release → one frameErr pulse, no rxValid, rxByte and dirControl unchanged, busy drops only after the line goes high.
- Pulse rxData low for 5 clocks (< CLKS_PER_BIT/2) → no rxValid, no frameErr, busy returns low within 12 clocks.
- Send unknown byte 0x41 after 'F' → rxValid with rxByte=0x41, no cmdValid, dirControl stays 0001; assert rst mid-frame of the next byte → all outputs 0, no pulses.
- With UART_CMD_RX_PARITY_EN: send 0x53 with correct even parity bit 0 → command applied. Send 0x53 with parity bit 1 → frameErr, commands hold.
